// File: rtl/autoc_delay_cmult_acc_if.sv
// Sample-stream and correlator-output bundle for the delay-conjugate-multiply-accumulate block.
// The master drives samples and flush; the slave returns the windowed correlation.
interface autoc_delay_cmult_acc_if #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 32
);
  localparam int AW = 2*WIDTH + 1 + $clog2(WINDOW);

  logic                    clear;
  logic                    strobe_in;
  logic signed [WIDTH-1:0] in_i;
  logic signed [WIDTH-1:0] in_q;
  logic                    strobe_out;
  logic signed [AW-1:0]    corr_i;
  logic signed [AW-1:0]    corr_q;
  logic                    window_full;

  modport master (
    output clear, strobe_in, in_i, in_q,
    input  strobe_out, corr_i, corr_q, window_full
  );

  modport slave (
    input  clear, strobe_in, in_i, in_q,
    output strobe_out, corr_i, corr_q, window_full
  );
endinterface

// File: rtl/autoc_delay_cmult_acc.sv
// Autocorrelation front end: x[n]*conj(x[n-DELAY]) summed over a sliding window of WINDOW products.
// Three-stage pipeline (capture, partial products, combine/accumulate); no backpressure.
module autoc_delay_cmult_acc #(
  parameter int WIDTH  = 16,
  parameter int DELAY  = 16,
  parameter int WINDOW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  autoc_delay_cmult_acc_if.slave bus
);
  localparam int PPW = 2*WIDTH;
  localparam int PW  = 2*WIDTH + 1;
  localparam int AW  = PW + $clog2(WINDOW);
  localparam int DPW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int HPW = $clog2(WINDOW);
  localparam int DCW = $clog2(DELAY + 1);
  localparam int WCW = $clog2(WINDOW + 1);

  localparam logic [DPW-1:0] DLY_LAST = DPW'(DELAY - 1);
  localparam logic [HPW-1:0] HST_LAST = HPW'(WINDOW - 1);
  localparam logic [DCW-1:0] DLY_MAX  = DCW'(DELAY);
  localparam logic [WCW-1:0] WIN_MAX  = WCW'(WINDOW);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

  logic [2*WIDTH-1:0] dly_mem  [DELAY];
  logic [2*PW-1:0]    hist_mem [WINDOW];

  logic [DPW-1:0] dly_ptr;
  logic [DCW-1:0] dly_cnt;
  logic [HPW-1:0] hist_ptr;
  logic [WCW-1:0] win_cnt;

  logic                    s1_v;
  logic signed [WIDTH-1:0] s1_xi, s1_xq, s1_di, s1_dq;
  logic                    s2_v;
  logic signed [PPW-1:0]   s2_ii, s2_qq, s2_qi, s2_iq;

  logic [AW-1:0] acc_i, acc_q;
  logic          strobe_out_r;
  logic          window_full_r;

  logic               take;
  logic [2*WIDTH-1:0] dly_rd;
  logic [2*PW-1:0]    hist_rd;
  logic [PW-1:0]      p_i, p_q;
  logic [AW-1:0]      p_i_x, p_q_x, old_i_x, old_q_x, sub_i, sub_q;

  assign take    = bus.strobe_in & ~bus.clear;
  assign dly_rd  = dly_mem[dly_ptr];
  assign hist_rd = hist_mem[hist_ptr];

  // Full-precision combine; one guard bit covers the (-2^(W-1))^2 * 2 corner.
  assign p_i = {s2_ii[PPW-1], s2_ii} + {s2_qq[PPW-1], s2_qq};
  assign p_q = {s2_qi[PPW-1], s2_qi} - {s2_iq[PPW-1], s2_iq};

  assign p_i_x   = {{(AW-PW){p_i[PW-1]}}, p_i};
  assign p_q_x   = {{(AW-PW){p_q[PW-1]}}, p_q};
  assign old_i_x = {{(AW-PW){hist_rd[2*PW-1]}}, hist_rd[2*PW-1:PW]};
  assign old_q_x = {{(AW-PW){hist_rd[PW-1]}}, hist_rd[PW-1:0]};
  assign sub_i   = (win_cnt == WIN_MAX) ? old_i_x : '0;
  assign sub_q   = (win_cnt == WIN_MAX) ? old_q_x : '0;

  always_ff @(posedge clk) begin
    if (take) dly_mem[dly_ptr] <= {bus.in_i, bus.in_q};
  end

  always_ff @(posedge clk) begin
    if (s2_v && !bus.clear) hist_mem[hist_ptr] <= {p_i, p_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_ptr       <= '0;
      dly_cnt       <= '0;
      hist_ptr      <= '0;
      win_cnt       <= '0;
      s1_v          <= 1'b0;
      s1_xi         <= '0;
      s1_xq         <= '0;
      s1_di         <= '0;
      s1_dq         <= '0;
      s2_v          <= 1'b0;
      s2_ii         <= '0;
      s2_qq         <= '0;
      s2_qi         <= '0;
      s2_iq         <= '0;
      acc_i         <= '0;
      acc_q         <= '0;
      strobe_out_r  <= 1'b0;
      window_full_r <= 1'b0;
    end else if (bus.clear) begin
      dly_ptr       <= '0;
      dly_cnt       <= '0;
      hist_ptr      <= '0;
      win_cnt       <= '0;
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      acc_i         <= '0;
      acc_q         <= '0;
      strobe_out_r  <= 1'b0;
      window_full_r <= 1'b0;
    end else begin
      // S1: capture sample and its lagged partner; a product exists only once the line is primed.
      s1_v <= take && (dly_cnt == DLY_MAX);
      if (take) begin
        s1_xi   <= bus.in_i;
        s1_xq   <= bus.in_q;
        s1_di   <= dly_rd[2*WIDTH-1:WIDTH];
        s1_dq   <= dly_rd[WIDTH-1:0];
        dly_ptr <= (dly_ptr == DLY_LAST) ? '0 : dly_ptr + 1'b1;
        if (dly_cnt != DLY_MAX) dly_cnt <= dly_cnt + 1'b1;
      end

      s2_v <= s1_v;
      if (s1_v) begin
        s2_ii <= s1_xi * s1_di;
        s2_qq <= s1_xq * s1_dq;
        s2_qi <= s1_xq * s1_di;
        s2_iq <= s1_xi * s1_dq;
      end

      strobe_out_r <= s2_v;
      if (s2_v) begin
        acc_i    <= acc_i + p_i_x - sub_i;
        acc_q    <= acc_q + p_q_x - sub_q;
        hist_ptr <= (hist_ptr == HST_LAST) ? '0 : hist_ptr + 1'b1;
        if (win_cnt != WIN_MAX) win_cnt <= win_cnt + 1'b1;
        if (win_cnt == WIN_LAST) window_full_r <= 1'b1;
      end
    end
  end

  assign bus.strobe_out  = strobe_out_r;
  assign bus.corr_i      = acc_i;
  assign bus.corr_q      = acc_q;
  assign bus.window_full = window_full_r;

endmodule
